register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//  Architectural register file plus pending-write scoreboard; the consumer of the writeback stage's
//  register write port (wb_reg_en/addr/data). Serves two registered read ports to decode, with
//  same-cycle write bypass, and tracks in-flight destination writes so decode can stall on RAW hazards.
//  Sits between decode (reads, issue marks) and writeback (writes, retire).
// PARAMETERS
//  NUM_REGS  32  number of architectural registers (index 0 hardwired to zero)
//  ADDR_W    5   register index width; NUM_REGS == 2**ADDR_W
//  DATA_W    32  register data width
//  PEND_W    2   width of per-register pending-write counter (max 2**PEND_W-1 in flight)
// PORTS
//  clock             in   1       system clock, all state updates on rising edge
//  reset             in   1       synchronous, active-high reset
//  wb_reg_en         in   1       writeback write enable; also retires one pending write
//  wb_reg_addr       in   ADDR_W  writeback destination register
//  wb_reg_data       in   DATA_W  writeback data
//  id_reg_addra      in   ADDR_W  decode read port A index
//  id_reg_addrb      in   ADDR_W  decode read port B index
//  id_reg_issue_en   in   1       decode issued an instruction writing id_reg_issue_addr
//  id_reg_issue_addr in   ADDR_W  destination of issued instruction
//  reg_id_dataa      out  DATA_W  port A read data (1-cycle latency)
//  reg_id_datab      out  DATA_W  port B read data (1-cycle latency)
//  reg_id_busya      out  1       port A register has pending write (1-cycle latency)
//  reg_id_busyb      out  1       port B register has pending write (1-cycle latency)
//  reg_err_overflow  out  1       sticky: issue attempted with counter saturated
//  reg_err_underflow out  1       sticky: retire at counter zero
//  dbg_reg_addr      in   ADDR_W  debug read index (REGFILE_DEBUG_EN only)
//  dbg_reg_data      out  DATA_W  debug read data (REGFILE_DEBUG_EN only)
// BEHAVIOUR
//  - Reset: all registers, counters, read/busy outputs, error flags -> 0. Write/issue in reset cycle discarded.
//  - Write: wb_reg_en && wb_reg_addr!=0 -> regs[addr] <= wb_reg_data at edge. Writes to r0 ignored.
//  - Read: at each edge reg_id_dataX <= (addrX==0) ? 0 : (wb_reg_en && wb_reg_addr==addrX) ? wb_reg_data
//    : regs[addrX]. Bypass makes same-cycle write visible; both ports may hit the same register.
//  - Scoreboard, per reg i!=0, counter pend[i]:
//      issue only  -> pend+1; if already max: hold, set reg_err_overflow
//      retire only -> pend-1; if already 0: hold, set reg_err_underflow
//      issue+retire same reg same cycle -> unchanged, no error
//      issue/retire of r0 -> ignored; pend[0] always 0
//  - Busy: reg_id_busyX <= next-state pend[addrX]!=0 (includes this cycle's issue/retire), so a
//    read that coincides with the final retire shows busy=0 and bypassed data together.
//  - Error flags sticky until reset; registers still written on underflow retire.
//  - No handshake/backpressure: every enabled write/issue is accepted in its cycle.
// CONFIGURATION
//  REGFILE_DEBUG_EN defined: dbg_reg_addr/dbg_reg_data present; dbg_reg_data <= regs[dbg_reg_addr]
//    each edge, 1-cycle latency, no bypass, r0 reads 0, reset value 0; no effect on other ports.
//  Undefined: both debug ports absent; functional behaviour otherwise identical.
// TESTING
//  1. Reset, then read A=5,B=0 -> dataa=0, datab=0, busy both 0, flags 0.
//  2. Write r7=0xDEADBEEF, next cycle read A=7 -> 0xDEADBEEF; write r0=0x1234, read B=0 -> 0.
//  3. Same cycle write r3=0xA5A5A5A5 and read A=3,B=3 -> next cycle both ports 0xA5A5A5A5.
//  4. Issue r9 x3, read A=9 -> busy=1; 4th issue -> overflow=1, count held 3; retire x3 -> busy=0.
//  5. Issue+retire r4 same cycle with count 1 -> count stays 1, busy=1; retire r4 at 0 -> underflow=1.
//  6. Assert reset mid-sequence with write r2 pending -> r2 reads 0, all counters/flags 0 next cycle.

Source files
------------

// File: rtl/register_file.sv
// Architectural register file with bypassed dual read ports and a pending-write scoreboard.
// Optional debug read port enabled by defining REGFILE_DEBUG_EN.
module register_file #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PEND_W   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_reg_en,
  input  logic [ADDR_W-1:0] wb_reg_addr,
  input  logic [DATA_W-1:0] wb_reg_data,
  input  logic [ADDR_W-1:0] id_reg_addra,
  input  logic [ADDR_W-1:0] id_reg_addrb,
  input  logic              id_reg_issue_en,
  input  logic [ADDR_W-1:0] id_reg_issue_addr,
  output logic [DATA_W-1:0] reg_id_dataa,
  output logic [DATA_W-1:0] reg_id_datab,
  output logic              reg_id_busya,
  output logic              reg_id_busyb,
  output logic              reg_err_overflow,
`ifdef REGFILE_DEBUG_EN
  output logic              reg_err_underflow,
  input  logic [ADDR_W-1:0] dbg_reg_addr,
  output logic [DATA_W-1:0] dbg_reg_data
`else
  output logic              reg_err_underflow
`endif
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] regs     [NUM_REGS];
  logic [PEND_W-1:0] pend     [NUM_REGS];
  logic [PEND_W-1:0] pend_nxt [NUM_REGS];

  logic              wr_v;
  logic              issue_v;
  logic              same_reg;
  logic              ovf_set;
  logic              udf_set;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  assign wr_v     = wb_reg_en && (wb_reg_addr != '0);
  assign issue_v  = id_reg_issue_en && (id_reg_issue_addr != '0);
  assign same_reg = wr_v && issue_v && (wb_reg_addr == id_reg_issue_addr);

  // Read mux with same-cycle writeback bypass
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (id_reg_addra != '0)
      rd_a = (wr_v && wb_reg_addr == id_reg_addra) ? wb_reg_data : regs[id_reg_addra];
    if (id_reg_addrb != '0)
      rd_b = (wr_v && wb_reg_addr == id_reg_addrb) ? wb_reg_data : regs[id_reg_addrb];
  end

  // Next pending counts; issue and retire of the same register cancel out
  always_comb begin
    pend_nxt = pend;
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    if (issue_v && !same_reg) begin
      if (pend[id_reg_issue_addr] == PEND_MAX)
        ovf_set = 1'b1;
      else
        pend_nxt[id_reg_issue_addr] = pend[id_reg_issue_addr] + PEND_W'(1);
    end
    if (wr_v && !same_reg) begin
      if (pend[wb_reg_addr] == '0)
        udf_set = 1'b1;
      else
        pend_nxt[wb_reg_addr] = pend[wb_reg_addr] - PEND_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
      reg_id_dataa      <= '0;
      reg_id_datab      <= '0;
      reg_id_busya      <= 1'b0;
      reg_id_busyb      <= 1'b0;
      reg_err_overflow  <= 1'b0;
      reg_err_underflow <= 1'b0;
    end else begin
      if (wr_v)
        regs[wb_reg_addr] <= wb_reg_data;
      for (int unsigned i = 0; i < NUM_REGS; i++)
        pend[i] <= pend_nxt[i];
      reg_id_dataa      <= rd_a;
      reg_id_datab      <= rd_b;
      reg_id_busya      <= (pend_nxt[id_reg_addra] != '0);
      reg_id_busyb      <= (pend_nxt[id_reg_addrb] != '0);
      reg_err_overflow  <= reg_err_overflow | ovf_set;
      reg_err_underflow <= reg_err_underflow | udf_set;
    end
  end

`ifdef REGFILE_DEBUG_EN
  // Debug read sees committed state only, no bypass
  always_ff @(posedge clock) begin
    if (reset)
      dbg_reg_data <= '0;
    else
      dbg_reg_data <= (dbg_reg_addr == '0) ? '0 : regs[dbg_reg_addr];
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: driver pushes model predictions, monitor pops and compares.
module tb_register_file;

  localparam int PMAX = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb_reg_en = 1'b0;
  logic [4:0]  wb_reg_addr = '0;
  logic [31:0] wb_reg_data = '0;
  logic [4:0]  id_reg_addra = '0;
  logic [4:0]  id_reg_addrb = '0;
  logic        id_reg_issue_en = 1'b0;
  logic [4:0]  id_reg_issue_addr = '0;
  logic [31:0] reg_id_dataa;
  logic [31:0] reg_id_datab;
  logic        reg_id_busya;
  logic        reg_id_busyb;
  logic        reg_err_overflow;
  logic        reg_err_underflow;
`ifdef REGFILE_DEBUG_EN
  logic [4:0]  dbg_reg_addr = '0;
  logic [31:0] dbg_reg_data;
`endif

  register_file dut (
    .clock             (clock),
    .reset             (reset),
    .wb_reg_en         (wb_reg_en),
    .wb_reg_addr       (wb_reg_addr),
    .wb_reg_data       (wb_reg_data),
    .id_reg_addra      (id_reg_addra),
    .id_reg_addrb      (id_reg_addrb),
    .id_reg_issue_en   (id_reg_issue_en),
    .id_reg_issue_addr (id_reg_issue_addr),
    .reg_id_dataa      (reg_id_dataa),
    .reg_id_datab      (reg_id_datab),
    .reg_id_busya      (reg_id_busya),
    .reg_id_busyb      (reg_id_busyb),
    .reg_err_overflow  (reg_err_overflow),
`ifdef REGFILE_DEBUG_EN
    .reg_err_underflow (reg_err_underflow),
    .dbg_reg_addr      (dbg_reg_addr),
    .dbg_reg_data      (dbg_reg_data)
`else
    .reg_err_underflow (reg_err_underflow)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] da;
    logic [31:0] db;
    logic        ba;
    logic        bb;
    logic        ov;
    logic        un;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] mregs [32];
  int          mpend [32];
  logic        movf;
  logic        mudf;
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    else
      passed++;
  endtask

  // Drive one cycle of stimulus and predict the registered outputs after the next edge
  task automatic cyc(input logic rst, input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] ra, input logic [4:0] rb, input logic ien, input logic [4:0] ia);
    exp_t e;
    int   np [32];
    @(negedge clock);
    reset = rst; wb_reg_en = wen; wb_reg_addr = wa; wb_reg_data = wd;
    id_reg_addra = ra; id_reg_addrb = rb; id_reg_issue_en = ien; id_reg_issue_addr = ia;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mregs[i] = '0; mpend[i] = 0; end
      movf = 1'b0; mudf = 1'b0;
      e.da = '0; e.db = '0; e.ba = 1'b0; e.bb = 1'b0; e.ov = 1'b0; e.un = 1'b0;
    end else begin
      e.da = (ra == 0) ? 32'h0 : (wen && wa == ra) ? wd : mregs[ra];
      e.db = (rb == 0) ? 32'h0 : (wen && wa == rb) ? wd : mregs[rb];
      np = mpend;
      if (ien && ia != 0) np[ia] = np[ia] + 1;
      if (wen && wa != 0) np[wa] = np[wa] - 1;
      for (int i = 0; i < 32; i++) begin
        if (np[i] > PMAX) begin movf = 1'b1; np[i] = PMAX; end
        if (np[i] < 0)    begin mudf = 1'b1; np[i] = 0;    end
      end
      mpend = np;
      e.ba = (mpend[ra] != 0);
      e.bb = (mpend[rb] != 0);
      e.ov = movf;
      e.un = mudf;
      if (wen && wa != 0) mregs[wa] = wd;
    end
    q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, compare one prediction per edge
  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("dataa",     reg_id_dataa,             mon_e.da);
      chk("datab",     reg_id_datab,             mon_e.db);
      chk("busya",     32'(reg_id_busya),        32'(mon_e.ba));
      chk("busyb",     32'(reg_id_busyb),        32'(mon_e.bb));
      chk("overflow",  32'(reg_err_overflow),    32'(mon_e.ov));
      chk("underflow", 32'(reg_err_underflow),   32'(mon_e.un));
    end
  end

  initial begin
    // Reset and idle read of r5/r0
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 5, 0, 0, 0);
    // Write r7, read it back; r0 write ignored
    cyc(0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 7, 7, 0, 0);
    cyc(0, 1, 0, 32'h00001234, 7, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Same-cycle bypass onto both ports
    cyc(0, 1, 3, 32'hA5A5A5A5, 3, 3, 0, 0);
    cyc(0, 0, 0, 0, 3, 7, 0, 0);
    // Fill r9 to saturation, overflow, then drain with bypassed final retire
    cyc(0, 0, 0, 0, 9, 0, 1, 9);
    cyc(0, 0, 0, 0, 9, 0, 1, 9);
    cyc(0, 0, 0, 0, 9, 9, 1, 9);
    cyc(0, 0, 0, 0, 9, 0, 1, 9);
    cyc(0, 1, 9, 32'h11111111, 9, 0, 0, 0);
    cyc(0, 1, 9, 32'h22222222, 9, 0, 0, 0);
    cyc(0, 1, 9, 32'h33333333, 9, 9, 0, 0);
    cyc(0, 0, 0, 0, 9, 0, 0, 0);
    // Issue+retire cancel on r4, then underflow
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 4, 0, 1, 4);
    cyc(0, 1, 4, 32'h44444444, 4, 4, 1, 4);
    cyc(0, 1, 4, 32'h55555555, 4, 0, 0, 0);
    cyc(0, 1, 4, 32'h66666666, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 4, 0, 0, 0);
    // r0 issue/retire ignored
    cyc(0, 1, 0, 32'h77777777, 0, 0, 1, 0);
    // Reset mid-sequence discards a coincident write and issue
    cyc(0, 1, 2, 32'h0BADF00D, 0, 0, 1, 6);
    cyc(1, 1, 2, 32'hCAFEF00D, 2, 6, 1, 2);
    cyc(0, 0, 0, 0, 2, 6, 0, 0);
    // Randomized traffic over a small register window to create hazards
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    end
    cyc(0, 0, 0, 0, 1, 2, 0, 0);
    @(negedge clock);
    @(negedge clock);
    chk("drain", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
